led_frame_arbiter: RTL and testbench

//  Shares the 8x8 LED matrix between two frame producers, A and B.

---
 rtl/led_frame_arbiter.sv | 130 +++++++++++++
 tb/tb_led_frame_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_frame_arbiter.sv
// Round-robin arbiter sharing the 8x8 LED matrix between frame producers A and B,
// holding each accepted frame for DWELL_CYCLES. Optional idle blanking: LED_ARB_BLANK_EN.
module led_frame_arbiter #(
    parameter logic [23:0] DWELL_CYCLES = 24'd12_000_000,
    parameter logic [23:0] IDLE_TIMEOUT = 24'd6_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [63:0] a_frame,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [63:0] b_frame,
    output logic        b_ready,
    output logic [63:0] frame_out,
    output logic        frame_strobe,
    output logic        owner,
    output logic        busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

`ifdef LED_ARB_BLANK_EN
    localparam bit LP_BLANK_EN = 1'b1;
`else
    localparam bit LP_BLANK_EN = 1'b0;
`endif

    if (DWELL_CYCLES == 24'd0 || (LP_BLANK_EN && IDLE_TIMEOUT == 24'd0)) begin : g_param_check
        $error("led_frame_arbiter: DWELL_CYCLES (and IDLE_TIMEOUT when blanking) must be nonzero");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic        r_last_grant;
    logic [63:0] r_frame;
    logic        r_strobe;
    logic        r_owner;
    logic        w_idle;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_hs;
    logic        w_blank;

    // Ready is also masked by rst so no handshake can be taken on a reset edge.
    always_comb begin
        w_idle    = (r_state == ST_IDLE) && !rst;
        w_grant_a = a_valid && (!b_valid || r_last_grant);
        w_grant_b = b_valid && (!a_valid || !r_last_grant);
        a_ready   = w_idle && w_grant_a;
        b_ready   = w_idle && w_grant_b;
        w_hs      = a_ready || b_ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = ST_DWELL;
                    w_cnt_nxt   = DWELL_CYCLES - 24'd1;
                end
            end
            ST_DWELL: begin
                if (r_cnt == 24'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef LED_ARB_BLANK_EN
    logic [23:0] r_idle_cnt;

    // Saturates at IDLE_TIMEOUT so the blank fires only on the single crossing cycle.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_IDLE || w_hs) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IDLE_TIMEOUT) begin
            r_idle_cnt <= r_idle_cnt + 24'd1;
        end
    end

    always_comb begin
        w_blank = (r_state == ST_IDLE) && !w_hs &&
                  (r_idle_cnt == IDLE_TIMEOUT - 24'd1) && (r_frame != '0);
    end
`else
    always_comb begin
        w_blank = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_frame      <= '0;
            r_strobe     <= 1'b0;
            r_owner      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_strobe <= w_hs || w_blank;
            if (w_hs) begin
                r_frame      <= a_ready ? a_frame : b_frame;
                r_owner      <= b_ready;
                r_last_grant <= b_ready;
            end else if (w_blank) begin
                r_frame <= '0;
            end
        end
    end

    assign frame_out    = r_frame;
    assign frame_strobe = r_strobe;
    assign owner        = r_owner;
    assign busy         = (r_state == ST_DWELL);

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed vector table plus hand sequences for led_frame_arbiter (DWELL=4, TIMEOUT=8);
// blanking checks follow LED_ARB_BLANK_EN.
module tb_led_frame_arbiter;

    localparam logic [63:0] FA  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] FB  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] FA2 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] FB2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] FC  = 64'h8000_0000_0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [63:0] a_frame = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [63:0] b_frame = '0;
    logic        b_ready;
    logic [63:0] frame_out;
    logic        frame_strobe;
    logic        owner;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic        rst;
        logic        av;
        logic [63:0] af;
        logic        bv;
        logic [63:0] bf;
        logic        ar;
        logic        br;
        logic [63:0] f;
        logic        s;
        logic        o;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    led_frame_arbiter #(
        .DWELL_CYCLES(24'd4),
        .IDLE_TIMEOUT(24'd8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a_valid(a_valid),
        .a_frame(a_frame),
        .a_ready(a_ready),
        .b_valid(b_valid),
        .b_frame(b_frame),
        .b_ready(b_ready),
        .frame_out(frame_out),
        .frame_strobe(frame_strobe),
        .owner(owner),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then settle before sampling.
    task automatic cycle_in(input logic r, input logic av, input logic [63:0] af,
                            input logic bv, input logic [63:0] bf);
        @(negedge clk);
        rst = r; a_valid = av; a_frame = af; b_valid = bv; b_frame = bf;
        #1;
    endtask

    task automatic add(input logic r, input logic av, input logic [63:0] af,
                       input logic bv, input logic [63:0] bf,
                       input logic ar, input logic br, input logic [63:0] f,
                       input logic s, input logic o, input logic bz);
        vec_t v;
        v.rst = r; v.av = av; v.af = af; v.bv = bv; v.bf = bf;
        v.ar = ar; v.br = br; v.f = f; v.s = s; v.o = o; v.busy = bz;
        vecs.push_back(v);
    endtask

    // Idle the inputs until busy drops; leaves the bench in the first idle cycle.
    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle_in(1'b0, 1'b0, '0, 1'b0, '0);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_idle_reached"}, 64'(seen), 64'd1);
    endtask

    task automatic load_a(input string name, input logic [63:0] fr);
        wait_idle(name);
        @(negedge clk);
        a_valid = 1'b1; a_frame = fr;
        #1;
        check({name, "_a_ready"}, 64'(a_ready), 64'd1);
        wait_idle(name);
        check({name, "_frame_held"}, frame_out, fr);
    endtask

    initial begin
        // rst, av, af, bv, bf | a_ready, b_ready, frame_out, strobe, owner, busy
        add(1, 0, '0,  0, '0,   0, 0, '0,  0, 0, 0);
        add(1, 1, FA,  0, '0,   0, 0, '0,  0, 0, 0);
        add(0, 1, FA,  0, '0,   1, 0, '0,  0, 0, 0);
        add(0, 0, '0,  0, '0,   0, 0, FA,  1, 0, 1);
        add(0, 0, '0,  0, '0,   0, 0, FA,  0, 0, 1);
        add(0, 0, '0,  0, '0,   0, 0, FA,  0, 0, 1);
        add(0, 0, '0,  0, '0,   0, 0, FA,  0, 0, 1);
        add(0, 0, '0,  0, '0,   0, 0, FA,  0, 0, 0);
        add(0, 1, FA2, 1, FB,   0, 1, FA,  0, 0, 0);
        add(0, 1, FA2, 1, FB,   0, 0, FB,  1, 1, 1);
        add(0, 1, FA2, 1, FB,   0, 0, FB,  0, 1, 1);
        add(0, 1, FA2, 1, FB,   0, 0, FB,  0, 1, 1);
        add(0, 1, FA2, 1, FB,   0, 0, FB,  0, 1, 1);
        add(0, 1, FA2, 1, FB,   1, 0, FB,  0, 1, 0);
        add(0, 1, FA2, 1, FB,   0, 0, FA2, 1, 0, 1);
        add(0, 1, FA2, 1, FB,   0, 0, FA2, 0, 0, 1);
        add(0, 1, FA2, 1, FB,   0, 0, FA2, 0, 0, 1);
        add(0, 1, FA2, 1, FB,   0, 0, FA2, 0, 0, 1);
        add(0, 1, FA2, 1, FB,   0, 1, FA2, 0, 0, 0);
        add(0, 0, '0,  1, FB2,  0, 0, FB,  1, 1, 1);
        add(0, 0, '0,  1, FB2,  0, 0, FB,  0, 1, 1);
        add(0, 0, '0,  0, '0,   0, 0, FB,  0, 1, 1);
        add(0, 0, '0,  0, '0,   0, 0, FB,  0, 1, 1);
        add(0, 0, '0,  0, '0,   0, 0, FB,  0, 1, 0);
        add(0, 1, FA,  0, '0,   1, 0, FB,  0, 1, 0);
        add(0, 0, '0,  0, '0,   0, 0, FA,  1, 0, 1);
        add(1, 1, FA,  0, '0,   0, 0, FA,  0, 0, 1);
        add(0, 1, FA2, 1, FB,   1, 0, '0,  0, 0, 0);
        add(0, 0, '0,  0, '0,   0, 0, FA2, 1, 0, 1);

        foreach (vecs[i]) begin
            cycle_in(vecs[i].rst, vecs[i].av, vecs[i].af, vecs[i].bv, vecs[i].bf);
            check($sformatf("v%0d_a_ready", i), 64'(a_ready), 64'(vecs[i].ar));
            check($sformatf("v%0d_b_ready", i), 64'(b_ready), 64'(vecs[i].br));
            check($sformatf("v%0d_frame_out", i), frame_out, vecs[i].f);
            check($sformatf("v%0d_strobe", i), 64'(frame_strobe), 64'(vecs[i].s));
            check($sformatf("v%0d_owner", i), 64'(owner), 64'(vecs[i].o));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
        end

`ifdef LED_ARB_BLANK_EN
        // Idle index 0 is the first cycle after busy falls; blank shows on index 8.
        load_a("blank", FA);
        for (int k = 1; k < 8; k++) begin
            cycle_in(1'b0, 1'b0, '0, 1'b0, '0);
            check($sformatf("blank_hold%0d", k), frame_out, FA);
            check($sformatf("blank_nostrobe%0d", k), 64'(frame_strobe), 64'd0);
        end
        cycle_in(1'b0, 1'b0, '0, 1'b0, '0);
        check("blank_frame_zero", frame_out, 64'd0);
        check("blank_strobe", 64'(frame_strobe), 64'd1);
        check("blank_owner_kept", 64'(owner), 64'd0);
        for (int k = 0; k < 12; k++) begin
            cycle_in(1'b0, 1'b0, '0, 1'b0, '0);
            check($sformatf("blank_once_strobe%0d", k), 64'(frame_strobe), 64'd0);
            check($sformatf("blank_stays%0d", k), frame_out, 64'd0);
        end

        load_a("race", FA2);
        for (int k = 1; k < 7; k++) begin
            cycle_in(1'b0, 1'b0, '0, 1'b0, '0);
            check($sformatf("race_hold%0d", k), frame_out, FA2);
        end
        cycle_in(1'b0, 1'b1, FC, 1'b0, '0);
        check("race_a_ready", 64'(a_ready), 64'd1);
        cycle_in(1'b0, 1'b0, '0, 1'b0, '0);
        check("race_frame_loaded", frame_out, FC);
        check("race_strobe", 64'(frame_strobe), 64'd1);
        check("race_busy", 64'(busy), 64'd1);
`else
        load_a("hold", FA);
        for (int k = 0; k < 110; k++) begin
            cycle_in(1'b0, 1'b0, '0, 1'b0, '0);
            check($sformatf("hold_frame%0d", k), frame_out, FA);
            check($sformatf("hold_nostrobe%0d", k), 64'(frame_strobe), 64'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
